// File: rtl/door_lock.sv
`default_nettype none
// ============================================================================
//  Module   : door_lock
//  Purpose  : Keypad password controller. Collects four 4-bit digits (one per
//             rising edge of enter), compares them with PASSWORD and flags
//             unlock on a match or error on a mismatch.
//  Options  : DOOR_LOCK_LOCKOUT_EN - when defined, MAX_FAILS consecutive
//             failures lock the keypad for LOCKOUT_CYCLES clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module door_lock #(
   parameter logic [15:0] PASSWORD       = 16'h4132,
   parameter int          MAX_FAILS      = 3,
   parameter int          LOCKOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enter,
   input  logic [3:0] digit,
   output logic       unlock,
   output logic       error
);

   localparam logic [2:0] c_st_collect = 3'd0;
   localparam logic [2:0] c_st_check   = 3'd1;
   localparam logic [2:0] c_st_open    = 3'd2;
   localparam logic [2:0] c_st_fail    = 3'd3;
`ifdef DOOR_LOCK_LOCKOUT_EN
   localparam logic [2:0] c_st_locked  = 3'd4;

   localparam int FAILS_W = $clog2(MAX_FAILS + 1);
   localparam int TIMER_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
   localparam logic [FAILS_W-1:0] c_fails_max = FAILS_W'(MAX_FAILS);
   localparam logic [TIMER_W-1:0] c_timer_end = TIMER_W'(LOCKOUT_CYCLES - 1);
`endif

   // Reject nonsensical configurations at elaboration time.
   if (MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
      $error("door_lock: MAX_FAILS and LOCKOUT_CYCLES must be at least 1");
   end

   logic [2:0]  r_state;
   logic [15:0] r_entry;
   logic [1:0]  r_count;
   logic        r_enter_d;
   logic        r_unlock;
   logic        r_error;
   logic        w_press;
   logic        w_match;
`ifdef DOOR_LOCK_LOCKOUT_EN
   logic [FAILS_W-1:0] r_fails;
   logic [TIMER_W-1:0] r_timer;
   logic [FAILS_W-1:0] w_fails_next;
`endif

   // A press is a rising edge of enter; holding enter high yields one digit.
   assign w_press = enter & ~r_enter_d;
   assign w_match = (r_entry == PASSWORD);

`ifdef DOOR_LOCK_LOCKOUT_EN
   // Saturating failure count as it would be after a failed check.
   assign w_fails_next = (r_fails == c_fails_max) ? r_fails : r_fails + 1'b1;
`endif

   assign unlock = r_unlock;
   assign error  = r_error;

   // Previous-enter register for press edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_enter_d <= 1'b0;
      end else begin
         r_enter_d <= enter;
      end
   end

   // Entry collection, comparison and result/lockout state machine.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= c_st_collect;
         r_entry  <= 16'h0000;
         r_count  <= 2'd0;
         r_unlock <= 1'b0;
         r_error  <= 1'b0;
`ifdef DOOR_LOCK_LOCKOUT_EN
         r_fails  <= '0;
         r_timer  <= '0;
`endif
      end else begin
         case (r_state)
            c_st_collect: begin
               if (w_press) begin
                  r_entry <= {r_entry[11:0], digit};
                  r_count <= r_count + 2'd1;
                  if (r_count == 2'd3) begin
                     r_state <= c_st_check;
                  end
               end
            end

            c_st_check: begin
               if (w_match) begin
                  r_state  <= c_st_open;
                  r_unlock <= 1'b1;
                  r_error  <= 1'b0;
`ifdef DOOR_LOCK_LOCKOUT_EN
                  r_fails  <= '0;
`endif
               end else begin
                  r_unlock <= 1'b0;
                  r_error  <= 1'b1;
`ifdef DOOR_LOCK_LOCKOUT_EN
                  r_fails  <= w_fails_next;
                  if (w_fails_next >= c_fails_max) begin
                     r_state <= c_st_locked;
                     r_timer <= '0;
                  end else begin
                     r_state <= c_st_fail;
                  end
`else
                  r_state  <= c_st_fail;
`endif
               end
            end

            c_st_open, c_st_fail: begin
               // The press that ends a result display is digit 1 of the next try.
               if (w_press) begin
                  r_unlock <= 1'b0;
                  r_error  <= 1'b0;
                  r_entry  <= {r_entry[11:0], digit};
                  r_count  <= 2'd1;
                  r_state  <= c_st_collect;
               end
            end

`ifdef DOOR_LOCK_LOCKOUT_EN
            c_st_locked: begin
               // Presses are ignored; the keypad reopens after the timeout.
               if (r_timer == c_timer_end) begin
                  r_state <= c_st_collect;
                  r_error <= 1'b0;
                  r_fails <= '0;
                  r_count <= 2'd0;
                  r_entry <= 16'h0000;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
`endif

            default: begin
               r_state  <= c_st_collect;
               r_count  <= 2'd0;
               r_unlock <= 1'b0;
               r_error  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_door_lock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_door_lock
//  Purpose  : Directed self-checking bench for door_lock. The lockout section
//             is compiled only when DOOR_LOCK_LOCKOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_door_lock;

   logic       clk;
   logic       reset;
   logic       enter;
   logic [3:0] digit;
   logic       unlock;
   logic       error;

   int n_tests = 0;
   int n_fail  = 0;

   door_lock #(
      .PASSWORD       (16'h4132),
      .MAX_FAILS      (3),
      .LOCKOUT_CYCLES (16)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enter  (enter),
      .digit  (digit),
      .unlock (unlock),
      .error  (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One-cycle press followed by enter low; returns on the negedge after the
   // accepting posedge.
   task automatic press(input logic [3:0] d);
      @(negedge clk);
      enter = 1'b1;
      digit = d;
      @(negedge clk);
      enter = 1'b0;
   endtask

   task automatic press4(input logic [15:0] code);
      press(code[15:12]);
      press(code[11:8]);
      press(code[7:4]);
      press(code[3:0]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      enter = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      enter = 1'b0;
      digit = 4'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Reset state
      check("reset_unlock", {31'd0, unlock}, 32'd0);
      check("reset_error",  {31'd0, error},  32'd0);

      // Correct code, latency and hold
      press4(16'h4132);
      check("check_cycle_unlock", {31'd0, unlock}, 32'd0);
      @(negedge clk);
      check("open_unlock", {31'd0, unlock}, 32'd1);
      check("open_error",  {31'd0, error},  32'd0);
      repeat (20) @(negedge clk);
      check("open_hold_unlock", {31'd0, unlock}, 32'd1);
      check("open_hold_error",  {31'd0, error},  32'd0);

      // Wrong code after reset
      do_reset();
      check("reset2_unlock", {31'd0, unlock}, 32'd0);
      press4(16'h1234);
      @(negedge clk);
      check("fail_error",  {31'd0, error},  32'd1);
      check("fail_unlock", {31'd0, unlock}, 32'd0);
      repeat (5) @(negedge clk);
      check("fail_hold_error", {31'd0, error}, 32'd1);

      // Partial entry discarded by reset
      press(4'h4);
      press(4'h1);
      do_reset();
      press4(16'h3241);
      @(negedge clk);
      check("partial_reset_error",  {31'd0, error},  32'd1);
      check("partial_reset_unlock", {31'd0, unlock}, 32'd0);

      // Recover from FAIL with the right code
      press4(16'h4132);
      @(negedge clk);
      check("retry_unlock", {31'd0, unlock}, 32'd1);

      // Held enter counts as one digit
      @(negedge clk);
      enter = 1'b1;
      digit = 4'h4;
      @(negedge clk);
      check("held_unlock_drop", {31'd0, unlock}, 32'd0);
      repeat (4) @(negedge clk);
      enter = 1'b0;
      @(negedge clk);
      check("held_no_check_unlock", {31'd0, unlock}, 32'd0);
      check("held_no_check_error",  {31'd0, error},  32'd0);
      press(4'h1);
      press(4'h3);
      press(4'h2);
      @(negedge clk);
      check("held_then_132_unlock", {31'd0, unlock}, 32'd1);

      // Last digit differs; next press clears error on its accepting edge
      press4(16'h4133);
      @(negedge clk);
      check("last_digit_error", {31'd0, error}, 32'd1);
      @(negedge clk);
      enter = 1'b1;
      digit = 4'h4;
      @(negedge clk);
      check("error_clear_on_press", {31'd0, error}, 32'd0);
      enter = 1'b0;
      press(4'h1);
      press(4'h3);
      press(4'h2);
      @(negedge clk);
      check("after_clear_unlock", {31'd0, unlock}, 32'd1);
      check("after_clear_error",  {31'd0, error},  32'd0);

`ifdef DOOR_LOCK_LOCKOUT_EN
      // Three consecutive failures lock the keypad for 16 cycles
      do_reset();
      for (int i = 0; i < 3; i++) begin
         press4(16'h1234);
         @(negedge clk);
         check($sformatf("lock_fail%0d_error", i), {31'd0, error}, 32'd1);
      end
      // Third CHECK edge was N+1; presses below cover edges N+2..N+9
      press4(16'h4132);
      check("locked_ignore_unlock", {31'd0, unlock}, 32'd0);
      check("locked_ignore_error",  {31'd0, error},  32'd1);
      repeat (7) @(negedge clk);
      check("locked_last_cycle_error", {31'd0, error}, 32'd1);
      @(negedge clk);
      check("lock_release_error", {31'd0, error}, 32'd0);
      press4(16'h4132);
      @(negedge clk);
      check("after_lock_unlock", {31'd0, unlock}, 32'd1);
      check("after_lock_error",  {31'd0, error},  32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
